frame_proc_core: RTL and testbench
==================================

// Module: frame_proc_core
// PURPOSE
//  Parametrised frame processor between camera frame buffer (mem0) and VGA frame buffer (mem1).
//  Per started frame: sweeps mem0 linearly, reduces/transforms each pixel by selectable mode, writes mem1.
//  Read latency, pixel widths, frame size and LeNet centre window are configurable.
//  Start/busy/done handshake replaces free-running counter; optional continuous mode.
// PARAMETERS
//  WIDTH      640  pixels per line
//  HEIGHT     480  lines per frame; N = WIDTH*HEIGHT
//  ADDR_W     19   address width; must satisfy 2**ADDR_W >= N
//  IN_W       8    input pixel width (din)
//  OUT_W      4    output pixel width (dout), OUT_W <= IN_W
//  RD_LAT     1    mem0 read latency in cycles (>=1)
//  WIN_W      256  LeNet centre window width  (<= WIDTH, even)
//  WIN_H      256  LeNet centre window height (<= HEIGHT, even)
//  CONT       0    1: restart automatically after frame_done, start not needed
// PORTS
//  clk25         in   1       pixel clock, all logic on rising edge
//  rst           in   1       synchronous reset, active-high
//  start         in   1       one-cycle request to process a frame
//  mode          in   2       0 pass, 1 invert, 2 threshold, 3 LeNet window mask
//  thresh        in   IN_W    threshold for mode 2
//  lenet_signal  in   1       enables masking in mode 3
//  din           in   IN_W    mem0 read data, valid RD_LAT cycles after addr_mem0
//  addr_mem0     out  ADDR_W  mem0 read address
//  addr_mem1     out  ADDR_W  mem1 write address
//  dout          out  OUT_W   mem1 write data
//  we            out  1       mem1 write enable
//  busy          out  1       frame in progress
//  frame_done    out  1       one-cycle pulse after last write
// BEHAVIOUR
//  Reset (sync, rst high at edge): state IDLE; addr_mem0=0, addr_mem1=0, dout=0, we=0, busy=0,
//   frame_done=0; delay pipeline cleared. Reset mid-frame aborts: no further we after that edge.
//  FSM: IDLE -> RUN on start (or CONT=1); RUN -> FLUSH after address N-1 issued;
//   FLUSH -> DONE after RD_LAT+1 cycles; DONE (1 cycle, frame_done=1) -> IDLE, or RUN if CONT=1/start.
//  start while busy ignored. mode, thresh, lenet_signal sampled at frame start, held for the frame.
//  Timing (cycle 0 = first cycle after start accepted): addr_mem0=i at cycle i, 0<=i<N;
//   write of pixel i at cycle i+RD_LAT+1: we=1, addr_mem1=i, dout=f(din). Exactly N writes/frame.
//   frame_done=1 at cycle N+RD_LAT+1; busy=1 on cycles 0..N+RD_LAT, 0 in IDLE/DONE.
//  Address/x/y (column/row) travel through RD_LAT-deep delay line alongside valid bit; no gaps.
//  x wraps WIDTH-1 -> 0 with y+1; y wraps at HEIGHT-1; addr_mem0 returns to 0 at frame end.
//  Pixel function, p = din[IN_W-1 -: OUT_W]:
//   mode 0: p; mode 1: ~p; mode 2: din>=thresh ? all ones : 0 (equality counts as ones).
//   mode 3: lenet_signal=1 -> p inside window, 0 outside; lenet_signal=0 -> p.
//   Window: x in [(WIDTH-WIN_W)/2, (WIDTH+WIN_W)/2-1], y likewise with HEIGHT/WIN_H; bounds inclusive.
//  we=0 and dout holds last value whenever no valid pixel emerges; addr_mem1 holds last address.
//  All comparisons unsigned; counters sized $clog2 of bound, no overflow beyond N-1.
// STRUCTURE
//  Package frame_proc_pkg: mode_e enum (MODE_PASS/INV/THR/WIN), state_e (IDLE/RUN/FLUSH/DONE).
//   Window bound localparams derived in module from parameters.
//  Sub-module pipe_delay #(DW, DEPTH): reset-clearable shift register for {valid, addr, x, y}.
//  Top: FSM + address/x/y counters + pixel function register stage.
// TESTING
//  1 WIDTH=8,HEIGHT=4,RD_LAT=1, mode0, din=addr*16: 32 writes, dout[i]=i%16; done at cycle 34.
//  2 RD_LAT=3 same frame: first we at cycle 4, last at 35, frame_done at 36; busy 0..35.
//  3 mode2 thresh=0x80, din 0x7F/0x80/0xFF -> dout 0x0/0xF/0xF.
//  4 mode3,WIN_W=4,WIN_H=2,lenet_signal=1, din=0xF0: dout=0xF only x in 2..5,y in 1..2; else 0.
//  5 start pulsed mid-frame, mode changed mid-frame: ignored; frame completes with original mode.
//  6 rst asserted at cycle 10 of frame: we=0 from next edge, outputs at reset values, IDLE;
//    new start gives full clean frame; CONT=1: back-to-back frames, addr_mem0 0 right after N-1.

Source files
------------

// File: rtl/frame_proc_pkg.sv
// Shared types for the camera-to-VGA frame processor.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package frame_proc_pkg;

  // Pixel transform selected per frame
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_THR  = 2'd2,
    MODE_WIN  = 2'd3
  } mode_e;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter width able to hold 0..bound-1, never narrower than one bit
  function automatic int cnt_w(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/frame_proc_core_pipe_delay.sv
// Fixed-depth shift register carrying {valid, addr, x, y} alongside the mem0 read.
// Latency: DEPTH cycles from d to q.
// Backpressure: none; shifts every cycle, cleared by reset.
module pipe_delay #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk25,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] sr [DEPTH];

  // Shift one stage per cycle; reset empties the line so no stale valid escapes
  always_ff @(posedge clk25) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/frame_proc_core.sv
// Sweeps mem0 once per frame, transforms each pixel by the latched mode, writes mem1.
// Latency: pixel i read at cycle i, written at cycle i+RD_LAT+1; frame_done at N+RD_LAT+1.
// Backpressure: none; mem1 always accepts, start is ignored while busy.
module frame_proc_core
  import frame_proc_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4,
  parameter int RD_LAT = 1,
  parameter int WIN_W  = 256,
  parameter int WIN_H  = 256,
  parameter int CONT   = 0
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [IN_W-1:0]   thresh,
  input  logic              lenet_signal,
  input  logic [IN_W-1:0]   din,
  output logic [ADDR_W-1:0] addr_mem0,
  output logic [ADDR_W-1:0] addr_mem1,
  output logic [OUT_W-1:0]  dout,
  output logic              we,
  output logic              busy,
  output logic              frame_done
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);
  localparam int FW = cnt_w(RD_LAT + 1);
  localparam int DW = 1 + ADDR_W + XW + YW;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(N - 1);
  localparam logic [XW-1:0]     LAST_X  = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     LAST_Y  = YW'(HEIGHT - 1);
  localparam logic [FW-1:0]     FL_LAST = FW'(RD_LAT);
  localparam logic              AUTO    = (CONT != 0);

  // Centre window, inclusive bounds
  localparam logic [XW-1:0] WX_LO = XW'((WIDTH - WIN_W) / 2);
  localparam logic [XW-1:0] WX_HI = XW'((WIDTH + WIN_W) / 2 - 1);
  localparam logic [YW-1:0] WY_LO = YW'((HEIGHT - WIN_H) / 2);
  localparam logic [YW-1:0] WY_HI = YW'((HEIGHT + WIN_H) / 2 - 1);

  state_e            state, state_nx;
  logic              launch;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [FW-1:0]     flush_cnt;
  mode_e             mode_q;
  logic [IN_W-1:0]   thr_q;
  logic              lenet_q;

  logic              d_vld;
  logic [ADDR_W-1:0] d_addr;
  logic [XW-1:0]     d_x;
  logic [YW-1:0]     d_y;
  logic [OUT_W-1:0]  p;
  logic [OUT_W-1:0]  pix;
  logic              in_win;

  // Next-state and status decode; a frame is launched from IDLE or straight out of DONE
  always_comb begin
    state_nx   = state;
    launch     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start || AUTO) begin
          state_nx = RUN;
          launch   = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (addr_mem0 == LAST_A) state_nx = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_cnt == FL_LAST) state_nx = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        if (start || AUTO) begin
          state_nx = RUN;
          launch   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, read address / raster counters, flush timer and per-frame settings
  always_ff @(posedge clk25) begin
    if (rst) begin
      state     <= IDLE;
      addr_mem0 <= '0;
      x_q       <= '0;
      y_q       <= '0;
      flush_cnt <= '0;
      mode_q    <= MODE_PASS;
      thr_q     <= '0;
      lenet_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        mode_q  <= mode_e'(mode);
        thr_q   <= thresh;
        lenet_q <= lenet_signal;
      end
      if (state == RUN) begin
        if (addr_mem0 == LAST_A) begin
          addr_mem0 <= '0;
          x_q       <= '0;
          y_q       <= '0;
        end else begin
          addr_mem0 <= addr_mem0 + 1'b1;
          if (x_q == LAST_X) begin
            x_q <= '0;
            y_q <= (y_q == LAST_Y) ? '0 : y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  pipe_delay #(
    .DW    (DW),
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk25 (clk25),
    .rst   (rst),
    .d     ({state == RUN, addr_mem0, x_q, y_q}),
    .q     ({d_vld, d_addr, d_x, d_y})
  );

  // Pixel transform on the read data lined up with its delayed coordinates
  always_comb begin
    p      = din[IN_W-1 -: OUT_W];
    in_win = (d_x >= WX_LO) && (d_x <= WX_HI) && (d_y >= WY_LO) && (d_y <= WY_HI);
    pix    = p;
    case (mode_q)
      MODE_PASS: pix = p;
      MODE_INV:  pix = ~p;
      MODE_THR:  pix = (din >= thr_q) ? '1 : '0;
      MODE_WIN:  pix = (lenet_q && !in_win) ? '0 : p;
      default:   pix = p;
    endcase
  end

  // mem1 write port; data and address hold when no pixel emerges
  always_ff @(posedge clk25) begin
    if (rst) begin
      we        <= 1'b0;
      addr_mem1 <= '0;
      dout      <= '0;
    end else begin
      we <= d_vld;
      if (d_vld) begin
        addr_mem1 <= d_addr;
        dout      <= pix;
      end
    end
  end

endmodule

// File: tb/tb_frame_proc_core.sv
// Self-checking bench: two instances (RD_LAT=1 start-driven, RD_LAT=3 continuous),
// memory models feeding din, per-cycle output logs checked against a reference pixel model.
module tb_frame_proc_core;

  localparam int W = 8, H = 4, N = W * H, AW = 5, WW = 4, WH = 2;
  localparam int LA = 1, LB = 3, MAXC = 2048;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // instance A
  logic          rstA, startA, lenetA, weA, busyA, doneA;
  logic [1:0]    modeA;
  logic [7:0]    threshA, dinA;
  logic [AW-1:0] a0A, a1A;
  logic [3:0]    doA;
  logic [7:0]    memA [N];

  // instance B
  logic          rstB, startB, lenetB, weB, busyB, doneB;
  logic [1:0]    modeB;
  logic [7:0]    threshB, dinB;
  logic [AW-1:0] a0B, a1B;
  logic [3:0]    doB;
  logic [7:0]    memB [N];
  logic [AW-1:0] hB [2];

  frame_proc_core #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .IN_W(8), .OUT_W(4), .RD_LAT(LA),
                    .WIN_W(WW), .WIN_H(WH), .CONT(0)) dut_a (
    .clk25(clk25), .rst(rstA), .start(startA), .mode(modeA), .thresh(threshA),
    .lenet_signal(lenetA), .din(dinA), .addr_mem0(a0A), .addr_mem1(a1A), .dout(doA),
    .we(weA), .busy(busyA), .frame_done(doneA));

  frame_proc_core #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .IN_W(8), .OUT_W(4), .RD_LAT(LB),
                    .WIN_W(WW), .WIN_H(WH), .CONT(1)) dut_b (
    .clk25(clk25), .rst(rstB), .start(startB), .mode(modeB), .thresh(threshB),
    .lenet_signal(lenetB), .din(dinB), .addr_mem0(a0B), .addr_mem1(a1B), .dout(doB),
    .we(weB), .busy(busyB), .frame_done(doneB));

  // mem0 models: one-cycle read for A, three-cycle read for B
  always @(posedge clk25) dinA <= memA[a0A];
  always @(posedge clk25) begin
    hB[0] <= a0B;
    hB[1] <= hB[0];
    dinB  <= memB[hB[1]];
  end

  // per-cycle output logs, sampled mid-cycle
  logic          lwA [MAXC], lbA [MAXC], ldA [MAXC], lwB [MAXC], lbB [MAXC], ldB [MAXC];
  logic [AW-1:0] l0A [MAXC], l1A [MAXC], l0B [MAXC], l1B [MAXC];
  logic [3:0]    lqA [MAXC], lqB [MAXC];

  always @(negedge clk25) begin
    if (cyc < MAXC) begin
      lwA[cyc] = weA; lbA[cyc] = busyA; ldA[cyc] = doneA;
      l0A[cyc] = a0A; l1A[cyc] = a1A;   lqA[cyc] = doA;
      lwB[cyc] = weB; lbB[cyc] = busyB; ldB[cyc] = doneB;
      l0B[cyc] = a0B; l1B[cyc] = a1B;   lqB[cyc] = doB;
    end
  end

  // reference pixel: x/y from the linear index, nibble = din/16
  function automatic logic [3:0] ref_pix(input int md, input int thr, input bit len,
                                         input int px, input int i);
    int x, y, p;
    bit inw;
    x = i % W;
    y = i / W;
    p = px / 16;
    inw = (x >= (W - WW) / 2) && (x <= (W + WW) / 2 - 1) &&
          (y >= (H - WH) / 2) && (y <= (H + WH) / 2 - 1);
    case (md)
      0:       return 4'(p);
      1:       return 4'(15 - p);
      2:       return (px >= thr) ? 4'hF : 4'h0;
      default: return (len && !inw) ? 4'h0 : 4'(p);
    endcase
  endfunction

  // pulse start on A with the given settings; t0 is the first cycle of the frame
  task automatic go_a(input int md, input int thr, input bit len, output int t0);
    @(negedge clk25);
    startA = 1'b1; modeA = 2'(md); threshA = 8'(thr); lenetA = len;
    @(posedge clk25);
    #1 t0 = cyc;
    @(negedge clk25);
    startA = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk25);
    n_chk++; if (weA !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) begin n_fail++; $display("FAIL reset_ctl_a we=%b busy=%b done=%b want 000", weA, busyA, doneA); end
    n_chk++; if (a0A !== '0 || a1A !== '0) begin n_fail++; $display("FAIL reset_addr_a a0=%0d a1=%0d want 0 0", a0A, a1A); end
    n_chk++; if (doA !== 4'h0) begin n_fail++; $display("FAIL reset_dout_a got %h want 0", doA); end
    n_chk++; if (weB !== 1'b0 || busyB !== 1'b0 || doneB !== 1'b0) begin n_fail++; $display("FAIL reset_ctl_b we=%b busy=%b done=%b want 000", weB, busyB, doneB); end
    n_chk++; if (a0B !== '0 || a1B !== '0 || doB !== 4'h0) begin n_fail++; $display("FAIL reset_out_b a0=%0d a1=%0d d=%h want 0", a0B, a1B, doB); end
    rstA = 1'b0;
    repeat (3) begin
      @(negedge clk25);
      n_chk++; if (busyA !== 1'b0 || weA !== 1'b0) begin n_fail++; $display("FAIL idle_no_start busy=%b we=%b want 0 0", busyA, weA); end
    end
  endtask

  task automatic test_pass_frame();
    int t0, c, i;
    for (int j = 0; j < N; j++) memA[j] = 8'(j * 16);
    go_a(0, 0, 1'b0, t0);
    repeat (N + LA + 3) @(negedge clk25);
    for (int k = 0; k <= N + LA + 2; k++) begin
      c = t0 + k;
      i = k - LA - 1;
      n_chk++; if (lbA[c] !== 1'(k <= N + LA)) begin n_fail++; $display("FAIL pass_busy k=%0d got %b want %b", k, lbA[c], k <= N + LA); end
      n_chk++; if (ldA[c] !== 1'(k == N + LA + 1)) begin n_fail++; $display("FAIL pass_done k=%0d got %b want %b", k, ldA[c], k == N + LA + 1); end
      n_chk++; if (lwA[c] !== 1'(i >= 0 && i < N)) begin n_fail++; $display("FAIL pass_we k=%0d got %b want %b", k, lwA[c], i >= 0 && i < N); end
      if (i >= 0 && i < N) begin
        n_chk++; if (l1A[c] !== AW'(i) || lqA[c] !== 4'(i % 16)) begin n_fail++; $display("FAIL pass_wr k=%0d got a=%0d d=%h want a=%0d d=%h", k, l1A[c], lqA[c], i, i % 16); end
      end
      if (k < N) begin
        n_chk++; if (l0A[c] !== AW'(k)) begin n_fail++; $display("FAIL pass_rdaddr k=%0d got %0d want %0d", k, l0A[c], k); end
      end
      if (k == N + LA + 1) begin
        n_chk++; if (l1A[c] !== AW'(N - 1) || lqA[c] !== 4'((N - 1) % 16) || l0A[c] !== '0) begin n_fail++; $display("FAIL pass_hold got a1=%0d d=%h a0=%0d want a1=%0d d=%h a0=0", l1A[c], lqA[c], l0A[c], N - 1, (N - 1) % 16); end
      end
    end
  endtask

  task automatic test_random_modes();
    int t0, md, thr, c, nw;
    bit len;
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < N; j++) memA[j] = 8'($urandom_range(0, 255));
      md  = (f < 4) ? f : int'($urandom_range(0, 3));
      thr = int'($urandom_range(0, 255));
      len = (f == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      go_a(md, thr, len, t0);
      repeat (N + LA + 3) @(negedge clk25);
      nw = 0;
      for (int k = 0; k <= N + LA + 2; k++) if (lwA[t0 + k] === 1'b1) nw++;
      n_chk++; if (nw != N) begin n_fail++; $display("FAIL rand_wcount frame=%0d got %0d want %0d", f, nw, N); end
      for (int i = 0; i < N; i++) begin
        c = t0 + i + LA + 1;
        n_chk++;
        if (lwA[c] !== 1'b1 || l1A[c] !== AW'(i) || lqA[c] !== ref_pix(md, thr, len, memA[i], i)) begin
          n_fail++;
          $display("FAIL rand_pix mode=%0d i=%0d got we=%b a=%0d d=%h want a=%0d d=%h", md, i, lwA[c], l1A[c], lqA[c], i, ref_pix(md, thr, len, memA[i], i));
        end
      end
      n_chk++; if (ldA[t0 + N + LA + 1] !== 1'b1) begin n_fail++; $display("FAIL rand_done frame=%0d got %b want 1", f, ldA[t0 + N + LA + 1]); end
    end
  endtask

  task automatic test_threshold();
    int t0, c, thr;
    logic [7:0] pat [3];
    logic [3:0] e;
    for (int r = 0; r < 2; r++) begin
      thr = (r == 0) ? 8'h80 : int'($urandom_range(1, 254));
      pat[0] = 8'(thr - 1); pat[1] = 8'(thr); pat[2] = (r == 0) ? 8'hFF : 8'(thr + 1);
      for (int j = 0; j < N; j++) memA[j] = pat[j % 3];
      go_a(2, thr, 1'b0, t0);
      repeat (N + LA + 3) @(negedge clk25);
      for (int i = 0; i < N; i++) begin
        c = t0 + i + LA + 1;
        e = (i % 3 == 0) ? 4'h0 : 4'hF;
        n_chk++; if (lqA[c] !== e || lwA[c] !== 1'b1) begin n_fail++; $display("FAIL thresh thr=%h din=%h got %h want %h", thr, memA[i], lqA[c], e); end
      end
    end
  endtask

  task automatic test_window();
    int t0, c, x, y;
    logic [3:0] e;
    for (int j = 0; j < N; j++) memA[j] = 8'hF0;
    for (int r = 0; r < 2; r++) begin
      go_a(3, 0, (r == 0), t0);
      repeat (N + LA + 3) @(negedge clk25);
      for (int i = 0; i < N; i++) begin
        c = t0 + i + LA + 1;
        x = i % W;
        y = i / W;
        e = (r == 1 || (x >= 2 && x <= 5 && y >= 1 && y <= 2)) ? 4'hF : 4'h0;
        n_chk++; if (lqA[c] !== e) begin n_fail++; $display("FAIL window lenet=%0d x=%0d y=%0d got %h want %h", r == 0, x, y, lqA[c], e); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int t0, c, nd, thr;
    for (int j = 0; j < N; j++) memA[j] = 8'($urandom_range(0, 255));
    thr = int'($urandom_range(0, 255));
    go_a(0, thr, 1'b0, t0);
    while (cyc < t0 + 10) @(negedge clk25);
    startA = 1'b1; modeA = 2'd1; threshA = 8'($urandom_range(0, 255)); lenetA = 1'b1;
    @(negedge clk25);
    startA = 1'b0;
    while (cyc < t0 + N) @(negedge clk25);
    startA = 1'b1; modeA = 2'd2;
    @(negedge clk25);
    startA = 1'b0;
    while (cyc < t0 + N + LA + 7) @(negedge clk25);
    for (int i = 0; i < N; i++) begin
      c = t0 + i + LA + 1;
      n_chk++; if (lqA[c] !== ref_pix(0, thr, 1'b0, memA[i], i) || lwA[c] !== 1'b1) begin n_fail++; $display("FAIL ignore_mode i=%0d got %h want %h", i, lqA[c], ref_pix(0, thr, 1'b0, memA[i], i)); end
    end
    nd = 0;
    for (int k = 0; k <= N + LA + 6; k++) if (ldA[t0 + k] === 1'b1) nd++;
    n_chk++; if (nd != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", nd); end
    for (int k = N + LA + 1; k <= N + LA + 6; k++) begin
      n_chk++; if (lbA[t0 + k] !== 1'b0 || lwA[t0 + k] !== 1'b0) begin n_fail++; $display("FAIL ignore_restart k=%0d busy=%b we=%b want 0 0", k, lbA[t0 + k], lwA[t0 + k]); end
    end
  endtask

  task automatic test_reset_abort();
    int t0, c, nw, thr;
    for (int j = 0; j < N; j++) memA[j] = 8'($urandom_range(0, 255));
    go_a(1, 0, 1'b0, t0);
    while (cyc < t0 + 10) @(negedge clk25);
    rstA = 1'b1;
    repeat (3) begin
      @(negedge clk25);
      n_chk++; if (weA !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) begin n_fail++; $display("FAIL abort_ctl we=%b busy=%b done=%b want 000", weA, busyA, doneA); end
      n_chk++; if (a0A !== '0 || a1A !== '0 || doA !== 4'h0) begin n_fail++; $display("FAIL abort_out a0=%0d a1=%0d d=%h want 0", a0A, a1A, doA); end
    end
    rstA = 1'b0;
    repeat (3) begin
      @(negedge clk25);
      n_chk++; if (busyA !== 1'b0 || weA !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy=%b we=%b want 0 0", busyA, weA); end
    end
    thr = int'($urandom_range(0, 255));
    go_a(2, thr, 1'b0, t0);
    repeat (N + LA + 3) @(negedge clk25);
    nw = 0;
    for (int k = 0; k <= N + LA + 2; k++) if (lwA[t0 + k] === 1'b1) nw++;
    n_chk++; if (nw != N) begin n_fail++; $display("FAIL abort_refr_wcount got %0d want %0d", nw, N); end
    for (int i = 0; i < N; i++) begin
      c = t0 + i + LA + 1;
      n_chk++; if (l1A[c] !== AW'(i) || lqA[c] !== ref_pix(2, thr, 1'b0, memA[i], i)) begin n_fail++; $display("FAIL abort_refr i=%0d got a=%0d d=%h want a=%0d d=%h", i, l1A[c], lqA[c], i, ref_pix(2, thr, 1'b0, memA[i], i)); end
    end
  endtask

  task automatic test_cont_lat3();
    int t0, tf, c, i, thr, md;
    for (int j = 0; j < N; j++) memB[j] = 8'($urandom_range(0, 255));
    thr = int'($urandom_range(0, 255));
    modeB = 2'd1; threshB = 8'h00; lenetB = 1'b0;
    @(negedge clk25);
    rstB = 1'b0;
    @(posedge clk25);
    #1 t0 = cyc;
    while (cyc < t0 + 20) @(negedge clk25);
    modeB = 2'd2; threshB = 8'(thr);
    while (cyc < t0 + 2 * (N + LB + 2) + 2) @(negedge clk25);
    for (int fr = 0; fr < 2; fr++) begin
      tf = t0 + fr * (N + LB + 2);
      md = (fr == 0) ? 1 : 2;
      for (int k = 0; k <= N + LB + 1; k++) begin
        c = tf + k;
        i = k - LB - 1;
        n_chk++; if (lbB[c] !== 1'(k <= N + LB)) begin n_fail++; $display("FAIL cont_busy fr=%0d k=%0d got %b want %b", fr, k, lbB[c], k <= N + LB); end
        n_chk++; if (ldB[c] !== 1'(k == N + LB + 1)) begin n_fail++; $display("FAIL cont_done fr=%0d k=%0d got %b want %b", fr, k, ldB[c], k == N + LB + 1); end
        n_chk++; if (lwB[c] !== 1'(i >= 0 && i < N)) begin n_fail++; $display("FAIL cont_we fr=%0d k=%0d got %b want %b", fr, k, lwB[c], i >= 0 && i < N); end
        n_chk++; if (l0B[c] !== ((k < N) ? AW'(k) : AW'(0))) begin n_fail++; $display("FAIL cont_rdaddr fr=%0d k=%0d got %0d want %0d", fr, k, l0B[c], (k < N) ? k : 0); end
        if (i >= 0 && i < N) begin
          n_chk++; if (l1B[c] !== AW'(i) || lqB[c] !== ref_pix(md, thr, 1'b0, memB[i], i)) begin n_fail++; $display("FAIL cont_wr fr=%0d i=%0d got a=%0d d=%h want a=%0d d=%h", fr, i, l1B[c], lqB[c], i, ref_pix(md, thr, 1'b0, memB[i], i)); end
        end
      end
    end
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0;
    modeA = 2'd0; modeB = 2'd1; threshA = 8'h00; threshB = 8'h00; lenetA = 1'b0; lenetB = 1'b0;
    for (int j = 0; j < N; j++) begin memA[j] = 8'h00; memB[j] = 8'h00; end
    test_reset();
    test_pass_frame();
    test_random_modes();
    test_threshold();
    test_window();
    test_start_ignored();
    test_reset_abort();
    test_cont_lat3();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cycle budget %0d exhausted at cycle %0d", MAXC, cyc);
    $fatal(1, "watchdog");
  end

endmodule
